unidad_pc: RTL and testbench
============================

// Module: unidad_pc
// PURPOSE
//  Parametrised program-counter unit for the RISC-V monocycle core; successor of the combinational PC+4 adder.
//  Holds the PC register, computes PC+INC and selects next PC from sequential/branch/jump/trap/mret sources.
//  Detects misaligned redirect targets, keeps trap return state (epc/badaddr) and cycle/retired counters.
//  Sits between the control unit/ALU (branch/jump targets) and instruction memory (pc output).
// PARAMETERS
//  XLEN          32            address/PC width in bits
//  INC           4             bytes added per sequential step
//  RESET_VECTOR  32'h0000_0000 PC value after reset
//  TRAP_VECTOR   32'h0000_0100 PC value on trap/misaligned entry
//  CNT_W         64            width of cycle and retired counters
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  stall          in   1       hold PC (no retire) this cycle
//  branch_taken   in   1       take branch_target
//  branch_target  in   XLEN    branch destination
//  jump           in   1       take jump_target (JAL/JALR)
//  jump_target    in   XLEN    jump destination
//  trap_req       in   1       synchronous exception/ecall request
//  mret           in   1       return to epc
//  pc             out  XLEN    current PC (registered)
//  pc_plus        out  XLEN    pc + INC, combinational, mod 2^XLEN
//  pc_valid       out  1       high when pc addresses a fetchable instruction
//  misalign_exc   out  1       one-cycle registered pulse: misaligned target caught
//  epc            out  XLEN    saved PC of last trapping instruction
//  badaddr        out  XLEN    offending target of last misaligned redirect
//  cycle_cnt      out  CNT_W   cycles spent in RUN
//  retired_cnt    out  CNT_W   instructions retired
// BEHAVIOUR
//  - Reset (async, any time): pc=RESET_VECTOR, state=BOOT, pc_valid=0, misalign_exc=0, epc=0, badaddr=0, counters=0.
//  - FSM: BOOT -> RUN after first clk edge with rst low (pc unchanged). RUN -> TRAP on trap_req or misaligned redirect.
//    TRAP -> RUN next cycle unconditionally. pc_valid=1 in RUN only; 0 in BOOT and TRAP.
//  - Next-PC priority in RUN (one-cycle latency, registered on edge):
//    1 trap_req         : pc<=TRAP_VECTOR, epc<=pc (overrides stall)
//    2 stall            : pc held; branch/jump/mret ignored
//    3 mret             : pc<=epc
//    4 jump             : pc<=jump_target
//    5 branch_taken     : pc<=branch_target
//    6 otherwise        : pc<=pc_plus
//  - Misaligned: selected jump/branch/mret target with target[1:0]!=0 -> pc<=TRAP_VECTOR, epc<=pc, badaddr<=target,
//    misalign_exc=1 for exactly the following cycle; state -> TRAP.
//  - TRAP state: pc held at TRAP_VECTOR, inputs ignored, no retire.
//  - pc_plus wraps: pc=XLEN'hFFFF_FFFC, INC=4 -> pc_plus=0; sequential step to 0 is legal, not a trap.
//  - cycle_cnt +1 every RUN cycle (incl. stalled); retired_cnt +1 per RUN cycle with !stall and no trap/misalign.
//    Both wrap silently at 2^CNT_W.
//  - Simultaneous jump & branch_taken: jump wins. trap_req & misaligned same cycle: trap_req wins, badaddr unchanged.
// STRUCTURE
//  - Package pc_pkg: typedef enum logic [1:0] {BOOT, RUN, TRAP} pc_state_t; typedef enum next-PC select
//    {SEL_SEQ, SEL_BR, SEL_JMP, SEL_RET, SEL_TRAP}; function is_misaligned(addr).
//  - One sub-module: sumador_pc #(XLEN, INC) — combinational pc + INC, replaces Sumador.
//  - Counters, FSM and PC register stay in unidad_pc.
// TESTING
//  1 rst high then low, no controls -> pc 0,0(BOOT),4,8,C; pc_valid 0 then 1; retired_cnt=3 after 3 RUN cycles.
//  2 pc=0x10, branch_taken, target=0x40 -> pc=0x40 next edge; with jump=1 target=0x80 same cycle -> pc=0x80.
//  3 pc=0x20, jump_target=0x42 -> pc=0x100, badaddr=0x42, epc=0x20, misalign_exc=1 one cycle, pc_valid=0 one cycle.
//  4 pc=0x30, stall=1 with branch_taken target=0x60 -> pc stays 0x30, retired unchanged, cycle_cnt +1.
//  5 pc=0x50, trap_req with stall=1 -> pc=0x100, epc=0x50; later mret -> pc=0x50.
//  6 pc=0xFFFF_FFFC sequential -> pc=0; assert rst mid-run -> pc=0, counters 0 immediately (no clk edge).

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit: FSM states,
// next-PC source encoding and the instruction alignment test.
package pc_pkg;

  localparam int unsigned ALIGN_BITS = 2;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_RET  = 3'd3,
    SEL_TRAP = 3'd4
  } pc_sel_t;

  // Instructions are word aligned; any set low bit makes a redirect illegal.
  function automatic logic is_misaligned(input logic [ALIGN_BITS-1:0] addr_lo);
    return addr_lo != '0;
  endfunction

endpackage

// File: rtl/sumador_pc.sv
// Combinational sequential-step adder: pc + INC, wrapping modulo 2^XLEN.
module sumador_pc #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned INC  = 4
) (
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_pc_plus
);

  assign o_pc_plus = i_pc + XLEN'(INC);

endmodule

// File: rtl/unidad_pc.sv
// Program-counter unit: PC register, next-PC selection, misaligned-redirect
// detection, trap return state and cycle/retired counters.
module unidad_pc
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     INC          = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned     CNT_W        = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             jump,
  input  logic [XLEN-1:0]  jump_target,
  input  logic             trap_req,
  input  logic             mret,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus,
  output logic             pc_valid,
  output logic             misalign_exc,
  output logic [XLEN-1:0]  epc,
  output logic [XLEN-1:0]  badaddr,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  pc_state_t        r_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_pc_valid;
  logic             r_misalign;
  logic [XLEN-1:0]  r_epc;
  logic [XLEN-1:0]  r_badaddr;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_retired;

  logic [XLEN-1:0]  w_pc_plus;
  pc_sel_t          w_sel;
  logic [XLEN-1:0]  w_target;
  logic             w_hold;
  logic             w_misalign;

  sumador_pc #(
    .XLEN (XLEN),
    .INC  (INC)
  ) u_sumador (
    .i_pc      (r_pc),
    .o_pc_plus (w_pc_plus)
  );

  // Stall outranks every redirect source except trap_req.
  always_comb begin
    w_sel    = SEL_SEQ;
    w_target = w_pc_plus;
    if (trap_req) begin
      w_sel    = SEL_TRAP;
      w_target = TRAP_VECTOR;
    end else if (mret) begin
      w_sel    = SEL_RET;
      w_target = r_epc;
    end else if (jump) begin
      w_sel    = SEL_JMP;
      w_target = jump_target;
    end else if (branch_taken) begin
      w_sel    = SEL_BR;
      w_target = branch_target;
    end
  end

  assign w_hold     = stall && !trap_req;
  assign w_misalign = !w_hold
                   && (w_sel inside {SEL_BR, SEL_JMP, SEL_RET})
                   && is_misaligned(w_target[ALIGN_BITS-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VECTOR;
      r_pc_valid <= 1'b0;
      r_misalign <= 1'b0;
      r_epc      <= '0;
      r_badaddr  <= '0;
      r_cycle    <= '0;
      r_retired  <= '0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        BOOT: begin
          r_state    <= RUN;
          r_pc_valid <= 1'b1;
        end
        RUN: begin
          r_cycle <= r_cycle + CNT_W'(1);
          if (w_sel == SEL_TRAP) begin
            r_pc       <= TRAP_VECTOR;
            r_epc      <= r_pc;
            r_state    <= TRAP;
            r_pc_valid <= 1'b0;
          end else if (w_hold) begin
            r_pc <= r_pc;
          end else if (w_misalign) begin
            r_pc       <= TRAP_VECTOR;
            r_epc      <= r_pc;
            r_badaddr  <= w_target;
            r_misalign <= 1'b1;
            r_state    <= TRAP;
            r_pc_valid <= 1'b0;
          end else begin
            r_pc      <= w_target;
            r_retired <= r_retired + CNT_W'(1);
          end
        end
        TRAP: begin
          r_state    <= RUN;
          r_pc_valid <= 1'b1;
        end
        default: begin
          r_state    <= BOOT;
          r_pc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pc           = r_pc;
  assign pc_plus      = w_pc_plus;
  assign pc_valid     = r_pc_valid;
  assign misalign_exc = r_misalign;
  assign epc          = r_epc;
  assign badaddr      = r_badaddr;
  assign cycle_cnt    = r_cycle;
  assign retired_cnt  = r_retired;

endmodule

// File: tb/tb_unidad_pc.sv
// Scoreboard bench for unidad_pc: stimulus queues expected values tagged by
// clock edge; a monitor pops and compares them on the falling edge.
module tb_unidad_pc;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_taken, jump, trap_req, mret;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_plus, epc, badaddr;
  logic        pc_valid, misalign_exc;
  logic [63:0] cycle_cnt, retired_cnt;

  unidad_pc #(
    .XLEN         (32),
    .INC          (4),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .CNT_W        (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .trap_req      (trap_req),
    .mret          (mret),
    .pc            (pc),
    .pc_plus       (pc_plus),
    .pc_valid      (pc_valid),
    .misalign_exc  (misalign_exc),
    .epc           (epc),
    .badaddr       (badaddr),
    .cycle_cnt     (cycle_cnt),
    .retired_cnt   (retired_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {S_PC, S_PLUS, S_VALID, S_MIS, S_EPC, S_BAD, S_CYC, S_RET} sig_t;
  typedef struct {
    int unsigned cyc;
    sig_t        sig;
    logic [63:0] val;
    string       nm;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  bit          stim_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(input sig_t s);
    case (s)
      S_PC:    return {32'd0, pc};
      S_PLUS:  return {32'd0, pc_plus};
      S_VALID: return {63'd0, pc_valid};
      S_MIS:   return {63'd0, misalign_exc};
      S_EPC:   return {32'd0, epc};
      S_BAD:   return {32'd0, badaddr};
      S_CYC:   return cycle_cnt;
      default: return retired_cnt;
    endcase
  endfunction

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        logic [63:0] a;
        e = q.pop_front();
        a = actual(e.sig);
        n_checks++;
        if (a === e.val) n_pass++;
        else $display("FAIL %s (edge %0d): got 0x%0h, expected 0x%0h", e.nm, e.cyc, a, e.val);
      end
    end
  end

  task automatic chk(input int unsigned d, input sig_t s, input logic [63:0] v, input string nm);
    q.push_back('{cyc + d, s, v, nm});
  endtask

  task automatic drv(input logic st, input logic br, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt, input logic tr, input logic mr);
    stall = st; branch_taken = br; branch_target = bt;
    jump = j; jump_target = jt; trap_req = tr; mret = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus
  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk(0, S_PC, 0, "rst_pc");       chk(0, S_VALID, 0, "rst_valid");
    chk(0, S_MIS, 0, "rst_mis");     chk(0, S_EPC, 0, "rst_epc");
    chk(0, S_BAD, 0, "rst_bad");     chk(0, S_CYC, 0, "rst_cyc");
    chk(0, S_RET, 0, "rst_ret");
    rst = 1'b0;

    chk(1, S_PC, 0, "boot_pc");      chk(1, S_VALID, 1, "boot_valid");
    chk(1, S_CYC, 0, "boot_cyc");    tick();
    chk(1, S_PC, 'h4, "seq_pc4");    chk(1, S_RET, 1, "seq_ret1");   tick();
    chk(1, S_PC, 'h8, "seq_pc8");    tick();
    chk(1, S_PC, 'hC, "seq_pcC");    chk(1, S_RET, 3, "seq_ret3");
    chk(1, S_CYC, 3, "seq_cyc3");    chk(1, S_PLUS, 'h10, "seq_plus"); tick();
    chk(1, S_PC, 'h10, "seq_pc10");  tick();

    drv(0, 1, 32'h40, 0, 0, 0, 0);
    chk(1, S_PC, 'h40, "br_pc");     tick();
    drv(0, 1, 32'h40, 1, 32'h80, 0, 0);
    chk(1, S_PC, 'h80, "jmp_wins");  chk(1, S_RET, 6, "jmp_ret");   tick();

    drv(0, 0, 0, 1, 32'h20, 0, 0);
    chk(1, S_PC, 'h20, "jmp_pc20");  tick();
    drv(0, 0, 0, 1, 32'h42, 0, 0);
    chk(1, S_PC, 'h100, "mis_pc");   chk(1, S_BAD, 'h42, "mis_bad");
    chk(1, S_EPC, 'h20, "mis_epc");  chk(1, S_MIS, 1, "mis_pulse");
    chk(1, S_VALID, 0, "mis_valid"); chk(1, S_RET, 7, "mis_ret");
    chk(1, S_CYC, 8, "mis_cyc");     tick();
    drv(0, 1, 32'h40, 0, 0, 0, 0);
    chk(1, S_PC, 'h100, "trap_hold"); chk(1, S_MIS, 0, "mis_clear");
    chk(1, S_VALID, 1, "trap_exit"); chk(1, S_CYC, 8, "trap_nocyc"); tick();

    drv(0, 0, 0, 1, 32'h30, 0, 0);
    chk(1, S_PC, 'h30, "jmp_pc30");  chk(1, S_RET, 8, "jmp30_ret"); tick();
    drv(1, 1, 32'h60, 0, 0, 0, 0);
    chk(1, S_PC, 'h30, "stall_pc");  chk(1, S_RET, 8, "stall_ret");
    chk(1, S_CYC, 10, "stall_cyc");  tick();

    drv(0, 0, 0, 1, 32'h50, 0, 0);
    chk(1, S_PC, 'h50, "jmp_pc50");  tick();
    drv(1, 0, 0, 0, 0, 1, 0);
    chk(1, S_PC, 'h100, "trap_pc");  chk(1, S_EPC, 'h50, "trap_epc");
    chk(1, S_VALID, 0, "trap_valid"); chk(1, S_RET, 9, "trap_ret");
    chk(1, S_BAD, 'h42, "trap_bad"); chk(1, S_CYC, 12, "trap_cyc"); tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk(1, S_VALID, 1, "trap2_exit"); tick();
    chk(1, S_PC, 'h104, "after_trap"); tick();
    drv(0, 0, 0, 0, 0, 0, 1);
    chk(1, S_PC, 'h50, "mret_pc");   chk(1, S_RET, 11, "mret_ret");  tick();

    drv(0, 0, 0, 1, 32'h43, 1, 0);
    chk(1, S_PC, 'h100, "tm_pc");    chk(1, S_EPC, 'h50, "tm_epc");
    chk(1, S_BAD, 'h42, "tm_bad");   chk(1, S_MIS, 0, "tm_mis");
    chk(1, S_CYC, 15, "tm_cyc");     tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk(1, S_VALID, 1, "tm_exit");   tick();

    drv(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    chk(1, S_PC, 'hFFFF_FFFC, "top_pc"); chk(1, S_PLUS, 0, "top_plus"); tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk(1, S_PC, 0, "wrap_pc");      chk(1, S_MIS, 0, "wrap_mis");
    chk(1, S_VALID, 1, "wrap_valid"); chk(1, S_RET, 13, "wrap_ret");
    chk(1, S_CYC, 17, "wrap_cyc");   tick();
    tick();

    #1;
    rst = 1'b1;
    chk(0, S_PC, 0, "arst_pc");      chk(0, S_CYC, 0, "arst_cyc");
    chk(0, S_RET, 0, "arst_ret");    chk(0, S_VALID, 0, "arst_valid");
    chk(0, S_EPC, 0, "arst_epc");    chk(0, S_BAD, 0, "arst_bad");
    tick();
    rst = 1'b0;
    chk(1, S_PC, 0, "reboot_pc");    chk(1, S_VALID, 1, "reboot_valid"); tick();
    chk(1, S_PC, 'h4, "reboot_pc4"); chk(1, S_RET, 1, "reboot_ret");    tick();

    repeat (3) @(negedge clk);
    stim_done = 1'b1;
  end

  initial begin
    fork
      wait (stim_done);
      #20000;
    join_any
    if (!stim_done) begin
      n_checks++;
      $display("FAIL timeout: stimulus did not complete, expected completion");
    end
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      $display("FAIL %s: never checked, expected 0x%0h", e.nm, e.val);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
